// File: rtl/unsigned_multiplier.sv
// Sequential shift-add unsigned multiplier: one multiplier bit per clock,
// WIDTH iterations to a registered 2*WIDTH-bit product with start/ready handshake.
module unsigned_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] number_A,
  input  logic [WIDTH-1:0] number_B,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo,
  output logic             overflow,
  output logic             busy,
  output logic             ready
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
  logic [WIDTH-1:0] prod_lo_q, prod_lo_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic [WIDTH:0]   sum;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mplr_d    = mplr_q;
    mcand_d   = mcand_q;
    count_d   = count_q;
    prod_hi_d = prod_hi_q;
    prod_lo_d = prod_lo_q;
    ovf_d     = ovf_q;
    busy_d    = busy_q;
    ready_d   = ready_q;
    // acc MSB is always zero after a shift, so adding the full acc equals
    // adding its low WIDTH bits; the carry lands in sum[WIDTH].
    sum = acc_q + {1'b0, (mplr_q[0] ? mcand_q : '0)};

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mplr_d  = number_A;
          mcand_d = number_B;
          acc_d   = '0;
          count_d = '0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        {acc_d, mplr_d} = {sum, mplr_q} >> 1;
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH-1)) begin
          prod_hi_d = acc_d[WIDTH-1:0];
          prod_lo_d = mplr_d;
          ovf_d     = |acc_d[WIDTH-1:0];
          busy_d    = 1'b0;
          ready_d   = 1'b1;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mplr_q    <= '0;
      mcand_q   <= '0;
      count_q   <= '0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mplr_q    <= mplr_d;
      mcand_q   <= mcand_d;
      count_q   <= count_d;
      prod_hi_q <= prod_hi_d;
      prod_lo_q <= prod_lo_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  assign product_hi = prod_hi_q;
  assign product_lo = prod_lo_q;
  assign overflow   = ovf_q;
  assign busy       = busy_q;
  assign ready      = ready_q;

endmodule

// File: tb/tb_unsigned_multiplier.sv
// Self-checking bench for unsigned_multiplier: directed and random products
// against a plain 64-bit multiply, plus start-ignore, reset-abort and streaming.
module tb_unsigned_multiplier;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a, b;
  logic [W-1:0] hi, lo;
  logic         ovf, busy, ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  unsigned_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .number_A(a), .number_B(b),
    .product_hi(hi), .product_lo(lo),
    .overflow(ovf), .busy(busy), .ready(ready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; a = '0; b = '0;
    #3;
    repeat (2) tick;
    checks++;
    if ({hi, lo, ovf, busy, ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got hi=%h lo=%h ovf=%b busy=%b ready=%b, want all 0", hi, lo, ovf, busy, ready);
    end
    reset = 1'b1;
  endtask

  task automatic test_products;
    logic [W-1:0]   ta, tb;
    logic [2*W-1:0] exp, prev;
    logic           prev_o, bad;
    int             lat;
    for (int n = 0; n < 16; n++) begin
      case (n)
        0: begin ta = 3;            tb = 5;            end
        1: begin ta = 32'hFFFFFFFF; tb = 32'hFFFFFFFF; end
        2: begin ta = 32'h12345678; tb = 0;            end
        3: begin ta = 0;            tb = 32'hDEADBEEF; end
        4: begin ta = 1;            tb = 32'hFFFFFFFF; end
        5: begin ta = 32'h80000000; tb = 32'h80000000; end
        default: begin
          ta = $urandom;
          tb = (n % 3 == 0) ? W'($urandom_range(0, 65535)) : $urandom;
        end
      endcase
      exp = 64'(ta) * 64'(tb);
      prev = {hi, lo}; prev_o = ovf;
      a = ta; b = tb; start = 1'b1;
      tick;
      start = 1'b0; a = $urandom; b = $urandom;
      lat = 0; bad = 1'b0;
      while (busy && lat < 40) begin
        if (ready || {hi, lo, ovf} !== {prev, prev_o}) bad = 1'b1;
        tick;
        lat++;
      end
      checks++;
      if (lat != W) begin
        errors++;
        $display("FAIL latency[%0d]: got %0d cycles, want %0d", n, lat, W);
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL run_hold[%0d]: ready or outputs changed during run, want held", n);
      end
      checks++;
      if ({ready, busy, hi, lo, ovf} !== {1'b1, 1'b0, exp, exp[2*W-1:W] != 0}) begin
        errors++;
        $display("FAIL product[%0d] %h*%h: got rdy=%b busy=%b %h_%h ovf=%b, want rdy=1 busy=0 %h ovf=%b",
                 n, ta, tb, ready, busy, hi, lo, ovf, exp, exp[2*W-1:W] != 0);
      end
      repeat (2) tick;
      checks++;
      if ({ready, busy, hi, lo} !== {1'b1, 1'b0, exp}) begin
        errors++;
        $display("FAIL done_hold[%0d]: got rdy=%b busy=%b %h_%h, want rdy=1 busy=0 %h", n, ready, busy, hi, lo, exp);
      end
    end
  endtask

  task automatic test_start_ignored;
    a = 7; b = 9; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (9) tick;
    start = 1'b1; a = 100; b = 100;
    tick;
    start = 1'b0;
    repeat (21) tick;
    checks++;
    if ({busy, ready} !== 2'b10) begin
      errors++;
      $display("FAIL ignore_e31: got busy=%b ready=%b, want busy=1 ready=0", busy, ready);
    end
    tick;
    checks++;
    if ({ready, busy, hi, lo, ovf} !== {1'b1, 1'b0, 64'd63, 1'b0}) begin
      errors++;
      $display("FAIL ignore_result: got rdy=%b busy=%b %h_%h ovf=%b, want rdy=1 busy=0 product 63 ovf=0", ready, busy, hi, lo, ovf);
    end
  endtask

  task automatic test_reset_abort;
    logic seen;
    int   lat;
    a = 32'h80000000; b = 2; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (15) tick;
    reset = 1'b0;
    #1;
    checks++;
    if ({hi, lo, ovf, busy, ready} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: got hi=%h lo=%h ovf=%b busy=%b ready=%b, want all 0", hi, lo, ovf, busy, ready);
    end
    repeat (2) tick;
    reset = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      tick;
      if (ready || busy || {hi, lo, ovf} !== '0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_idle: got activity after abort, want idle with zero outputs");
    end
    a = 6; b = 7; start = 1'b1;
    tick;
    start = 1'b0;
    lat = 0;
    while (!ready && lat < 40) begin tick; lat++; end
    checks++;
    if ({lat, hi, lo, ovf} !== {W, 64'd42, 1'b0}) begin
      errors++;
      $display("FAIL after_abort: got lat=%0d %h_%h ovf=%b, want lat=%0d product 42 ovf=0", lat, hi, lo, ovf, W);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0]   oa [3];
    logic [W-1:0]   ob [3];
    logic [2*W-1:0] exp, prev;
    logic           prev_o, bad;
    oa = '{32'd1, 32'd2, 32'h10000};
    ob = '{32'd1, 32'd3, 32'h10000};
    prev = {hi, lo}; prev_o = ovf;
    a = oa[0]; b = ob[0]; start = 1'b1;
    tick;
    for (int r = 0; r < 3; r++) begin
      exp = 64'(oa[r]) * 64'(ob[r]);
      if (r < 2) begin a = oa[r+1]; b = ob[r+1]; end
      bad = 1'b0;
      for (int k = 0; k < 31; k++) begin
        if (ready || !busy || {hi, lo, ovf} !== {prev, prev_o}) bad = 1'b1;
        tick;
      end
      if (ready || !busy || {hi, lo, ovf} !== {prev, prev_o}) bad = 1'b1;
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL stream_run[%0d]: ready early, busy dropped or prior product not held", r);
      end
      tick;
      checks++;
      if ({ready, busy, hi, lo, ovf} !== {1'b1, 1'b0, exp, exp[2*W-1:W] != 0}) begin
        errors++;
        $display("FAIL stream_result[%0d]: got rdy=%b busy=%b %h_%h ovf=%b, want rdy=1 busy=0 %h ovf=%b",
                 r, ready, busy, hi, lo, ovf, exp, exp[2*W-1:W] != 0);
      end
      prev = exp; prev_o = (exp[2*W-1:W] != 0);
      if (r == 2) start = 1'b0;
      tick;
    end
    checks++;
    if ({ready, busy, hi, lo, ovf} !== {1'b1, 1'b0, 64'h1_0000_0000, 1'b1}) begin
      errors++;
      $display("FAIL stream_end: got rdy=%b busy=%b %h_%h ovf=%b, want rdy=1 busy=0 hi=1 lo=0 ovf=1", ready, busy, hi, lo, ovf);
    end
  endtask

  initial begin
    test_reset;
    test_products;
    test_start_ignored;
    test_reset_abort;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
